// File: rtl/ext_pkg.sv
// Shared encodings for the immediate extension unit: op codes, FIFO occupancy
// states and the occupancy transition helper.
package ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'b00,
    EXT_SIGN   = 2'b01,
    EXT_HIGH   = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_op_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  localparam int FIFO_DEPTH = 2;

  // A simultaneous push and pop leaves the occupancy unchanged.
  function automatic occ_t occ_next(input occ_t cur, input logic push, input logic pop);
    occ_t nxt;
    nxt = cur;
    case ({push, pop})
      2'b10:   nxt = (cur == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   nxt = (cur == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ext_core.sv
// Stateless immediate extension. With EXT_BRANCH_EN defined op 11 is the branch
// offset form; otherwise op 11 is flagged illegal and yields zero.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  data,
  input  ext_op_t          op,
  output logic [OUT_W-1:0] result,
  output logic             illegal
);

  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("ext_core: OUT_W must be at least IN_W+2");
  end

  logic [OUT_W-1:0] sext;
  assign sext = {{(OUT_W-IN_W){data[IN_W-1]}}, data};

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      EXT_ZERO: result = {{(OUT_W-IN_W){1'b0}}, data};
      EXT_SIGN: result = sext;
      EXT_HIGH: result = {data, {(OUT_W-IN_W){1'b0}}};
      EXT_BRANCH: begin
`ifdef EXT_BRANCH_EN
        result = sext << 2;
`else
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ext_unit.sv
// Extension unit: ext_core feeding a 2-entry result FIFO with valid/ready
// handshakes and a sticky, saturating illegal-op counter (see EXT_BRANCH_EN).
module ext_unit
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt
);

  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("ext_unit: OUT_W must be at least IN_W+2");
  end

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  occ_t             occ;
  logic [OUT_W-1:0] core_result;
  logic             core_illegal;
  logic             push;
  logic             pop;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .data    (in_data),
    .op      (ext_op_t'(in_op)),
    .result  (core_result),
    .illegal (core_illegal)
  );

  // Ready depends only on state and reset, never on out_ready.
  assign in_ready  = (occ != OCC_FULL) && rst_n;
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ      <= OCC_EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      occ <= occ_next(occ, push, pop);
      if (push) begin
        mem[wr_ptr] <= core_result;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && core_illegal) begin
        err_flag <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ext_unit.sv
// Self-checking bench for ext_unit: table of extension vectors plus directed
// backpressure, saturation and mid-operation reset sequences.
module tb_ext_unit;
  import ext_pkg::*;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             err_flag;
  logic [CNT_W-1:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_err_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [31:0] exp_data;
    logic        illegal;
    string       name;
  } vec_t;

  vec_t vecs[9];

  ext_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [1:0] op,
                               input logic [15:0] data, input logic ready);
    in_valid  = valid;
    in_op     = op;
    in_data   = data;
    out_ready = ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] stopping");
  end

  initial begin
    vecs[0] = '{EXT_ZERO, 16'h8001, 32'h00008001, 1'b0, "zero_8001"};
    vecs[1] = '{EXT_SIGN, 16'h8001, 32'hFFFF8001, 1'b0, "sign_8001"};
    vecs[2] = '{EXT_HIGH, 16'h1234, 32'h12340000, 1'b0, "high_1234"};
    vecs[3] = '{EXT_SIGN, 16'h7FFF, 32'h00007FFF, 1'b0, "sign_7fff"};
    vecs[4] = '{EXT_ZERO, 16'hFFFF, 32'h0000FFFF, 1'b0, "zero_ffff"};
    vecs[5] = '{EXT_HIGH, 16'hFFFF, 32'hFFFF0000, 1'b0, "high_ffff"};
`ifdef EXT_BRANCH_EN
    vecs[6] = '{EXT_BRANCH, 16'hFFFF, 32'hFFFFFFFC, 1'b0, "branch_ffff"};
    vecs[7] = '{EXT_BRANCH, 16'h0001, 32'h00000004, 1'b0, "branch_0001"};
    vecs[8] = '{EXT_BRANCH, 16'h8000, 32'hFFFE0000, 1'b0, "branch_8000"};
`else
    vecs[6] = '{EXT_BRANCH, 16'hFFFF, 32'h00000000, 1'b1, "branch_ffff"};
    vecs[7] = '{EXT_BRANCH, 16'h0001, 32'h00000000, 1'b1, "branch_0001"};
    vecs[8] = '{EXT_BRANCH, 16'h8000, 32'h00000000, 1'b1, "branch_8000"};
`endif

    // Reset with a request presented; it must not be taken.
    rst_n = 1'b0;
    applyStimulus(1'b1, EXT_SIGN, 16'h1234, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_err_flag", 32'(err_flag), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b1);
    @(negedge clk);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    tick();

    // Each vector: accept, result one cycle later, then popped.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].data, 1'b1);
      @(negedge clk);
      checkOutput({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      applyStimulus(1'b0, 2'b00, 16'h0, 1'b1);
      if (vecs[i].illegal && exp_err_cnt < 255) exp_err_cnt++;
      @(negedge clk);
      checkOutput({vecs[i].name, "_out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({vecs[i].name, "_out_data"}, out_data, vecs[i].exp_data);
      checkOutput({vecs[i].name, "_err_flag"}, 32'(err_flag), 32'(exp_err_cnt != 0));
      checkOutput({vecs[i].name, "_err_cnt"}, 32'(err_cnt), 32'(exp_err_cnt));
      tick();
    end
    @(negedge clk);
    checkOutput("drained_out_valid", 32'(out_valid), 32'd0);
    checkOutput("drained_out_data", out_data, 32'h0);
    tick();

    // Backpressure: A and B fill the FIFO, C stalls until the first pop.
    applyStimulus(1'b1, EXT_ZERO, 16'hAAAA, 1'b0);
    @(negedge clk);
    checkOutput("bp_ready_a", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b1, EXT_SIGN, 16'hBBBB, 1'b0);
    @(negedge clk);
    checkOutput("bp_ready_b", 32'(in_ready), 32'd1);
    checkOutput("bp_head_a", out_data, 32'h0000AAAA);
    tick();
    applyStimulus(1'b1, EXT_HIGH, 16'hCCCC, 1'b0);
    @(negedge clk);
    checkOutput("bp_ready_c", 32'(in_ready), 32'd0);
    checkOutput("bp_head_a_full", out_data, 32'h0000AAAA);
    tick();
    @(negedge clk);
    checkOutput("bp_hold_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_data", out_data, 32'h0000AAAA);
    tick();
    applyStimulus(1'b1, EXT_HIGH, 16'hCCCC, 1'b1);
    @(negedge clk);
    checkOutput("bp_no_comb_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_pop_a", out_data, 32'h0000AAAA);
    tick();
    @(negedge clk);
    checkOutput("bp_ready_after_pop", 32'(in_ready), 32'd1);
    checkOutput("bp_pop_b", out_data, 32'hFFFFBBBB);
    tick();
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b1);
    @(negedge clk);
    checkOutput("bp_c_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_pop_c", out_data, 32'hCCCC0000);
    tick();
    @(negedge clk);
    checkOutput("bp_empty", 32'(out_valid), 32'd0);
    tick();

`ifndef EXT_BRANCH_EN
    // 300 back-to-back illegal ops saturate the counter without wrapping.
    applyStimulus(1'b1, EXT_BRANCH, 16'h0001, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b1);
    exp_err_cnt = (exp_err_cnt + 300 > 255) ? 255 : exp_err_cnt + 300;
    @(negedge clk);
    checkOutput("sat_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    checkOutput("sat_err_flag", 32'(err_flag), 32'd1);
    checkOutput("sat_out_data", out_data, 32'h0);
    checkOutput("sat_out_valid", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("sat_drained", 32'(out_valid), 32'd0);
    tick();
`endif

    // Reset with two results buffered and a request pending.
    applyStimulus(1'b1, EXT_SIGN, 16'h8001, 1'b0);
    tick();
    applyStimulus(1'b1, EXT_ZERO, 16'h0042, 1'b0);
    tick();
    applyStimulus(1'b1, EXT_ZERO, 16'h0077, 1'b0);
    @(negedge clk);
    checkOutput("mid_full_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_head", out_data, 32'hFFFF8001);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_in_reset_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b0);
    exp_err_cnt = 0;
    @(negedge clk);
    checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_out_data", out_data, 32'h0);
    checkOutput("mid_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    checkOutput("mid_err_flag", 32'(err_flag), 32'd0);
    checkOutput("mid_ready", 32'(in_ready), 32'd1);
    tick();

    // The unit works normally after the mid-operation reset.
    applyStimulus(1'b1, EXT_HIGH, 16'hFFFF, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 16'h0, 1'b1);
    @(negedge clk);
    checkOutput("post_out_valid", 32'(out_valid), 32'd1);
    checkOutput("post_out_data", out_data, 32'hFFFF0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
